// File: rtl/tlp_dual_port_fifo_pkg.sv
// Shared constants and types for the TLP FIFO feeding the fragmentation controller.
package Fragmentation_Package;

  localparam int unsigned TLP_FIFO_WIDTH     = 128;
  localparam int unsigned TLP_FIFO_ADD_WIDTH = 4;
  localparam int unsigned TLP_FIFO_DEPTH     = 2 ** TLP_FIFO_ADD_WIDTH;

  typedef enum logic {
    FIFO_ONE = 1'b0,
    FIFO_TWO = 1'b1
  } fifo_xfer_mode_e;

  // Words requested by a 1/2-word transfer, sized like the occupancy count.
  function automatic logic [TLP_FIFO_ADD_WIDTH:0] xfer_words(input logic en,
                                                            input fifo_xfer_mode_e mode);
    if (!en) return '0;
    return (mode == FIFO_TWO) ? (TLP_FIFO_ADD_WIDTH + 1)'(2) : (TLP_FIFO_ADD_WIDTH + 1)'(1);
  endfunction

endpackage

// File: rtl/tlp_dual_port_fifo_if.sv
// Write, read and status bundle between assembler, TLP FIFO and fragmentation controller.
interface tlp_dual_port_fifo_if;
  import Fragmentation_Package::*;

  logic                          wr_en;
  fifo_xfer_mode_e               wr_mode;
  logic [TLP_FIFO_WIDTH-1:0]     wr_data_1;
  logic [TLP_FIFO_WIDTH-1:0]     wr_data_2;
  logic [TLP_FIFO_ADD_WIDTH:0]   Free;
  logic                          Full;
  logic [TLP_FIFO_ADD_WIDTH:0]   Count;
  logic                          rd_en;
  fifo_xfer_mode_e               rd_mode;
  logic [TLP_FIFO_WIDTH-1:0]     rd_data_1;
  logic [TLP_FIFO_WIDTH-1:0]     rd_data_2;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output wr_en, wr_mode, wr_data_1, wr_data_2, rd_en, rd_mode,
    input  Free, Full, Count, rd_data_1, rd_data_2, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_mode, wr_data_1, wr_data_2, rd_en, rd_mode,
    output Free, Full, Count, rd_data_1, rd_data_2, overflow, underflow
  );

  modport TLP_FIFO_FRAGMENTATION (
    input  Count, rd_data_1, rd_data_2,
    output rd_en, rd_mode
  );

endinterface

// File: rtl/tlp_fifo_mem.sv
// Register file with two write ports and two asynchronous read ports; cleared on reset.
module tlp_fifo_mem #(
  parameter int unsigned Width = 128,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_1,
  input  logic [AddrW-1:0] waddr_1,
  input  logic [Width-1:0] wdata_1,
  input  logic             we_2,
  input  logic [AddrW-1:0] waddr_2,
  input  logic [Width-1:0] wdata_2,
  input  logic [AddrW-1:0] raddr_1,
  output logic [Width-1:0] rdata_1,
  input  logic [AddrW-1:0] raddr_2,
  output logic [Width-1:0] rdata_2
);

  logic [Width-1:0] mem_q [2**AddrW];

  // Port 2 is assigned last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AddrW; i++) mem_q[i] <= '0;
    end else begin
      if (we_1) mem_q[waddr_1] <= wdata_1;
      if (we_2) mem_q[waddr_2] <= wdata_2;
    end
  end

  assign rdata_1 = mem_q[raddr_1];
  assign rdata_2 = mem_q[raddr_2];

endmodule

// File: rtl/tlp_dual_port_fifo.sv
// Show-ahead TLP FIFO: pushes and pops 1 or 2 words per cycle, reports registered occupancy.
module tlp_dual_port_fifo
  import Fragmentation_Package::*;
(
  input logic              clk,
  input logic              rst,
  tlp_dual_port_fifo_if.slave bus
);

  localparam int unsigned AW = TLP_FIFO_ADD_WIDTH;
  localparam int unsigned W  = TLP_FIFO_WIDTH;
  localparam logic [AW:0] DepthCnt = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] IdxOne = {{(AW-1){1'b0}}, 1'b1};

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, free_q, free_d;
  logic          full_q, full_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic [AW:0]   wr_n, rd_n, rd_take, wr_take;
  logic          rd_ok, wr_ok;
  logic [AW-1:0] wr_idx_1, wr_idx_2, rd_idx_1, rd_idx_2;

  assign wr_n = xfer_words(bus.wr_en, bus.wr_mode);
  assign rd_n = xfer_words(bus.rd_en, bus.rd_mode);

  // Reads see only the registered count; a same-cycle accepted read frees space for writes.
  assign rd_ok   = (rd_n <= count_q);
  assign rd_take = rd_ok ? rd_n : '0;
  assign wr_ok   = (wr_n <= free_q + rd_take);
  assign wr_take = wr_ok ? wr_n : '0;

  assign wr_idx_1 = wr_ptr_q[AW-1:0];
  assign wr_idx_2 = wr_idx_1 + IdxOne;
  assign rd_idx_1 = rd_ptr_q[AW-1:0];
  assign rd_idx_2 = rd_idx_1 + IdxOne;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + wr_take;
    rd_ptr_d    = rd_ptr_q + rd_take;
    count_d     = count_q + wr_take - rd_take;
    free_d      = DepthCnt - count_d;
    full_d      = (count_d == DepthCnt);
    overflow_d  = overflow_q | (bus.wr_en & ~wr_ok);
    underflow_d = underflow_q | (bus.rd_en & ~rd_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      free_q      <= DepthCnt;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      free_q      <= free_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  tlp_fifo_mem #(
    .Width (W),
    .AddrW (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_1    (bus.wr_en & wr_ok),
    .waddr_1 (wr_idx_1),
    .wdata_1 (bus.wr_data_1),
    .we_2    (bus.wr_en & wr_ok & (bus.wr_mode == FIFO_TWO)),
    .waddr_2 (wr_idx_2),
    .wdata_2 (bus.wr_data_2),
    .raddr_1 (rd_idx_1),
    .rdata_1 (bus.rd_data_1),
    .raddr_2 (rd_idx_2),
    .rdata_2 (bus.rd_data_2)
  );

  assign bus.Count     = count_q;
  assign bus.Free      = free_q;
  assign bus.Full      = full_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_tlp_dual_port_fifo.sv
// Directed bench for tlp_dual_port_fifo: fill/drain, over/underflow, wrap and reset cases.
module tb_tlp_dual_port_fifo;
  import Fragmentation_Package::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  tlp_dual_port_fifo_if bus ();

  tlp_dual_port_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cycle(input logic we, input logic wm, input logic [127:0] d1,
                       input logic [127:0] d2, input logic re, input logic rm);
    bus.wr_en     = we;
    bus.wr_mode   = fifo_xfer_mode_e'(wm);
    bus.wr_data_1 = d1;
    bus.wr_data_2 = d2;
    bus.rd_en     = re;
    bus.rd_mode   = fifo_xfer_mode_e'(rm);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_mode = FIFO_ONE; bus.wr_data_1 = '0; bus.wr_data_2 = '0;
    bus.rd_en = 1'b0; bus.rd_mode = FIFO_ONE;
    do_reset();

    check_val("rst_count", bus.Count, 0);
    check_val("rst_free", bus.Free, 16);
    check_val("rst_full", bus.Full, 0);
    check_val("rst_rd1", bus.rd_data_1, 0);
    check_val("rst_rd2", bus.rd_data_2, 0);
    check_val("rst_ovf", bus.overflow, 0);
    check_val("rst_udf", bus.underflow, 0);

    // 1: fill with 16 single writes
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 128'(i), '0, 1'b0, 1'b0);
    check_val("fill_count", bus.Count, 16);
    check_val("fill_full", bus.Full, 1);
    check_val("fill_free", bus.Free, 0);
    check_val("fill_rd1", bus.rd_data_1, 128'h1);
    check_val("fill_rd2", bus.rd_data_2, 128'h2);

    // 2: write into a full FIFO
    cycle(1'b1, 1'b0, 128'h99, '0, 1'b0, 1'b0);
    check_val("ovf_flag", bus.overflow, 1);
    check_val("ovf_count", bus.Count, 16);
    check_val("ovf_rd1", bus.rd_data_1, 128'h1);

    // 3: drain in pairs
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("pair%0d_rd1", i), bus.rd_data_1, 128'(2 * i + 1));
      check_val($sformatf("pair%0d_rd2", i), bus.rd_data_2, 128'(2 * i + 2));
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    end
    check_val("drain_count", bus.Count, 0);
    check_val("drain_udf", bus.underflow, 0);
    check_val("drain_free", bus.Free, 16);

    // 4: double read with only one word present
    cycle(1'b1, 1'b0, 128'h55, '0, 1'b0, 1'b0);
    check_val("one_count", bus.Count, 1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    check_val("udf_flag", bus.underflow, 1);
    check_val("udf_count", bus.Count, 1);
    check_val("udf_rd1", bus.rd_data_1, 128'h55);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check_val("single_rd_count", bus.Count, 0);

    // 5: park pointers at 15, refill so the FIFO straddles the wrap
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 128'hdead, 128'hbeef, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 128'hdead, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check_val("park_count", bus.Count, 0);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b1, 128'(32'h200 + 2 * i), 128'(32'h201 + 2 * i), 1'b0, 1'b0);
    check_val("wrap_full", bus.Full, 1);
    check_val("wrap_rd1", bus.rd_data_1, 128'h200);
    check_val("wrap_rd2", bus.rd_data_2, 128'h201);
    cycle(1'b1, 1'b1, 128'h210, 128'h211, 1'b1, 1'b1);
    check_val("rw_full_count", bus.Count, 16);
    check_val("rw_full_ovf", bus.overflow, 0);
    check_val("rw_full_udf", bus.underflow, 0);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("wrap%0d_rd1", i), bus.rd_data_1, 128'(32'h202 + 2 * i));
      check_val($sformatf("wrap%0d_rd2", i), bus.rd_data_2, 128'(32'h203 + 2 * i));
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    end
    check_val("wrap_drain_count", bus.Count, 0);

    // 6: read and write together on an empty FIFO, then reset mid-stream
    cycle(1'b1, 1'b1, 128'hA, 128'hB, 1'b1, 1'b0);
    check_val("empty_rw_udf", bus.underflow, 1);
    check_val("empty_rw_count", bus.Count, 2);
    check_val("empty_rw_rd1", bus.rd_data_1, 128'hA);
    check_val("empty_rw_rd2", bus.rd_data_2, 128'hB);
    rst = 1'b1;
    cycle(1'b1, 1'b1, 128'hC, 128'hD, 1'b0, 1'b0);
    rst = 1'b0;
    check_val("mid_rst_count", bus.Count, 0);
    check_val("mid_rst_rd1", bus.rd_data_1, 0);
    check_val("mid_rst_rd2", bus.rd_data_2, 0);
    check_val("mid_rst_udf", bus.underflow, 0);
    check_val("mid_rst_free", bus.Free, 16);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
